fpga_uart_led_top: RTL and testbench

//  Top-level FPGA block that links to an external Arduino over UART (8N1, 9600 baud).

---
 rtl/fpga_uart_led_top.sv | 170 +++++++++++++++++
 tb/tb_fpga_uart_led_top.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fpga_uart_led_top.sv
// UART (8N1) link to an external controller: each good received byte drives a
// one-hot LED bank from its two LSBs and is echoed back unchanged on tx.
`timescale 1ns/1ps
module fpga_uart_led_top #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [3:0] leds
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic [3:0]      leds_q, leds_d;
  logic            pend_q, pend_d;
  logic [7:0]      pend_data_q, pend_data_d;
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_q, tx_d;

  // Receiver: half-bit wait qualifies the start bit, then full-bit steps land on bit centres.
  always_comb begin
    // NOTE: every signal gets its default first so no path can infer a latch.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (!rx_sync_q) begin
        rx_state_d = RX_START;
        rx_cnt_d   = '0;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        if (rx_sync_q) begin
          rx_valid_d = 1'b1;
          rx_state_d = RX_IDLE;
        end else rx_state_d = RX_WAIT_HIGH;
      end else rx_cnt_d = rx_cnt_q + CNT_ONE;
      RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    leds_d = leds_q;
    if (rx_valid_q) leds_d = 4'b0001 << rx_shift_q[1:0];
  end

  // Transmitter plus the single-entry holding register feeding it.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_d        = tx_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (pend_q) begin
          tx_state_d = TX_START;
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_shift_d = pend_data_q;
          pend_d     = 1'b0;
        end
      end
      TX_START: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = TX_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
      end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      TX_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_d       = tx_shift_q[1];
        end
      end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      TX_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
      end else tx_cnt_d = tx_cnt_q + CNT_ONE;
      default: tx_state_d = TX_IDLE;
    endcase
    // A fresh byte always wins over a pending one, even on the cycle TX takes it.
    if (rx_valid_q) begin
      pend_d      = 1'b1;
      pend_data_d = rx_shift_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_valid_q  <= 1'b0;
      leds_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_valid_q  <= rx_valid_d;
      leds_q      <= leds_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_q        <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_fpga_uart_led_top.sv
// Self-checking bench: directed and random UART frames against a byte-level
// model of LED decode and echo order; tx is decoded independently at bit centres.
`timescale 1ns/1ps
module tb_fpga_uart_led_top;

  localparam int CPB    = 16;
  localparam int BIT_NS = CPB * 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx;
  logic [3:0] leds;

  always #5 clk = ~clk;

  fpga_uart_led_top #(.CLK_FREQ(100_000_000), .BAUD(6_250_000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .tx   (tx),
    .leds (leds)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_leds = 4'b0000;
  logic [3:0] led_tab[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  bit         mon_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bits at index >= nbits are left idle-high, as a short frame would be.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = (i < nbits) ? data[i] : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    if (!stop_bit) begin
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic do_frame(input logic [7:0] data, input int nbits, input bit good, input string tag);
    logic [7:0] mask;
    logic [7:0] eff;
    mask = 8'((1 << nbits) - 1);
    eff  = data | ~mask;
    if (good) begin
      exp_q.push_back(eff);
      exp_leds = led_tab[eff[1:0]];
    end
    send_frame(data, nbits, good ? 1'b1 : 1'b0);
    check({tag, "_leds"}, leds, exp_leds);
  endtask

  task automatic wait_echo(input string tag);
    for (int t = 0; t < 40 * CPB && exp_q.size() != 0; t++) @(negedge clk);
    check({tag, "_echo_drained"}, exp_q.size(), 0);
  endtask

  // tx monitor: decode frames at bit centres and match against the expected queue.
  initial begin
    logic       s, st;
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge tx);
      #(BIT_NS / 2 + 5);
      s = tx;
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        b[i] = tx;
      end
      #(BIT_NS);
      st = tx;
      if (mon_en) begin
        check("echo_start_bit", s, 1'b0);
        check("echo_stop_bit", st, 1'b1);
        check("echo_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("echo_byte", b, e);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [7:0] d;
    bit         good;
    int         t;

    #100;
    check("reset_tx", tx, 1'b1);
    check("reset_leds", leds, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("idle_tx", tx, 1'b1);
    check("idle_leds", leds, 4'b0000);

    do_frame(8'h02, 2, 1'b1, "short_fe");
    wait_echo("short_fe");
    do_frame(8'h01, 2, 1'b1, "short_fd");
    wait_echo("short_fd");
    do_frame(8'h03, 8, 1'b1, "byte_03");
    wait_echo("byte_03");

    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch_leds", leds, exp_leds);
    check("glitch_tx", tx, 1'b1);

    do_frame(8'h55, 8, 1'b0, "frame_err");
    repeat (11 * CPB) @(negedge clk);
    check("frame_err_tx", tx, 1'b1);
    do_frame(8'h01, 8, 1'b1, "after_err");
    wait_echo("after_err");

    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      do_frame(d, 8, good, "rand");
      repeat ($urandom_range(0, 3) * CPB) @(negedge clk);
    end
    wait_echo("rand");

    do_frame(8'hA1, 8, 1'b1, "b2b_a1");
    do_frame(8'hA2, 8, 1'b1, "b2b_a2");
    for (t = 0; t < 20 * CPB && exp_q.size() > 1; t++) @(negedge clk);
    check("b2b_a1_echoed", exp_q.size(), 1);
    for (t = 0; t < 2 * CPB && tx !== 1'b0; t++) @(negedge clk);
    check("b2b_a2_start", tx, 1'b0);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midecho_rst_tx", tx, 1'b1);
    check("midecho_rst_leds", leds, 4'b0000);
    repeat (12 * CPB) @(negedge clk);
    exp_q.delete();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("post_rst_tx", tx, 1'b1);
    check("post_rst_leds", leds, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
